// File: rtl/sp_ram_port_ctrl.sv
// Slave-port controller for sp_ram: req/gnt bus to SRAM strobes, plus a zero-fill clear engine.
// Latency: grant in the request cycle, response (rvalid/rdata/err) exactly one cycle later.
// Backpressure: none on responses; gnt_o is held low for the whole clear sequence.
module sp_ram_port_ctrl #(
  parameter int ADDR_WIDTH     = 14,
  parameter int NUM_WORDS      = 16384,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  input  logic                  clear_i,
  output logic                  init_done_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int WA   = ADDR_WIDTH - 2;
  localparam int LAST = NUM_WORDS / 4 - 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WA-1:0]   cnt_q, cnt_d;
  logic            grant;
  logic            in_range;

  // Response pipeline: one stage, remembers what kind of response is due.
  logic            rsp_vld_q;
  logic            rsp_rd_q;
  logic            rsp_err_q;
  logic [31:0]     hold_q;

  assign in_range = (addr_i < 32'(NUM_WORDS));
  assign grant    = (state_q == ST_RUN) && req_i;

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and SRAM strobes; the clear engine owns the SRAM port while clearing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_o       = 1'b0;
    init_done_o = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    ram_be_o    = be_i;
    ram_wdata_o = wdata_i;
    case (state_q)
      ST_CLEAR: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = {cnt_q, 2'b00};
        ram_be_o    = 4'hF;
        ram_wdata_o = '0;
        if (cnt_q == WA'(LAST)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        init_done_o = 1'b1;
        gnt_o       = req_i;
        if (req_i && in_range) begin
          ram_en_o = 1'b1;
          ram_we_o = we_i;
        end
        // A request granted alongside clear_i still completes normally.
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Register the response type for the cycle after each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_vld_q <= grant;
      rsp_rd_q  <= grant && in_range && !we_i;
      rsp_err_q <= grant && !in_range;
    end
  end

  // Hold register keeps the last read data; writes and errors leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (rsp_vld_q && rsp_rd_q) begin
      hold_q <= ram_rdata_i;
    end
  end

  // Read responses pass SRAM data straight through; errors force zero.
  always_comb begin
    rvalid_o = rsp_vld_q;
    err_o    = rsp_vld_q && rsp_err_q;
    rdata_o  = hold_q;
    if (rsp_vld_q && rsp_rd_q) begin
      rdata_o = ram_rdata_i;
    end else if (rsp_vld_q && rsp_err_q) begin
      rdata_o = '0;
    end
  end

endmodule

// File: tb/tb_sp_ram_port_ctrl.sv
// Bench for sp_ram_port_ctrl with a 64-byte array and clear on reset.
// Latency: checks outputs every falling edge against a transaction-level model.
// Backpressure: none; directed stimulus drives the bus one cycle at a time.
module tb_sp_ram_port_ctrl;

  localparam int AW = 14;
  localparam int NW = 64;
  localparam int NWORDS = NW / 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_i;
  logic          gnt_o;
  logic [31:0]   addr_i;
  logic          we_i;
  logic [3:0]    be_i;
  logic [31:0]   wdata_i;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic          clear_i;
  logic          init_done_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]    ram_be_o;
  logic [31:0]   ram_wdata_o;
  logic [31:0]   ram_rdata_i = '0;

  int n_chk  = 0;
  int n_pass = 0;

  sp_ram_port_ctrl #(.ADDR_WIDTH(AW), .NUM_WORDS(NW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .clear_i(clear_i), .init_done_o(init_done_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: registered read, byte-masked write.
  bit [31:0] sram [4096];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) sram[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= sram[ram_addr_o[AW-1:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level model: golden memory, clearing flag, one pending response.
  bit [31:0] gmem [NWORDS];
  bit        m_clr  = 1'b1;
  int        m_idx  = 0;
  bit        m_pv   = 1'b0;
  bit        m_prd  = 1'b0;
  bit        m_perr = 1'b0;
  bit [31:0] m_pdat = '0;
  bit [31:0] m_hold = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rvalid", 32'(rvalid_o), 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_init_done", 32'(init_done_o), 32'h0);
      chk("rst_gnt", 32'(gnt_o), 32'h0);
      m_clr = 1'b1; m_idx = 0; m_pv = 1'b0; m_hold = '0;
    end else begin
      bit        inr;
      bit [31:0] w;
      inr = (addr_i < NW);
      chk("init_done", 32'(init_done_o), 32'(!m_clr));
      chk("gnt", 32'(gnt_o), 32'(!m_clr && req_i));
      if (m_clr) begin
        chk("clr_en_we", {30'h0, ram_en_o, ram_we_o}, 32'h3);
        chk("clr_addr", 32'(ram_addr_o), 32'(m_idx * 4));
        chk("clr_be_wdata", ram_wdata_o | 32'(ram_be_o != 4'hF), 32'h0);
      end else if (req_i && inr) begin
        chk("acc_en_we", {30'h0, ram_en_o, ram_we_o}, {30'h0, 1'b1, we_i});
        chk("acc_addr", 32'(ram_addr_o), {addr_i[31:2], 2'b00} & 32'h3FFF);
        if (we_i) begin
          chk("acc_be", 32'(ram_be_o), 32'(be_i));
          chk("acc_wdata", ram_wdata_o, wdata_i);
        end
      end else begin
        chk("idle_en", 32'(ram_en_o), 32'h0);
      end
      chk("rvalid", 32'(rvalid_o), 32'(m_pv));
      chk("err", 32'(err_o), 32'(m_pv && m_perr));
      if (m_pv && m_prd)       chk("rdata_read", rdata_o, m_pdat);
      else if (m_pv && m_perr) chk("rdata_err", rdata_o, 32'h0);
      else                     chk("rdata_hold", rdata_o, m_hold);
      // Advance the model to the next cycle.
      if (m_pv && m_prd) m_hold = m_pdat;
      m_pv = !m_clr && req_i;
      m_prd = m_pv && inr && !we_i;
      m_perr = m_pv && !inr;
      if (m_prd) m_pdat = gmem[addr_i[5:2]];
      if (m_clr) begin
        gmem[m_idx] = '0;
        m_idx++;
        if (m_idx == NWORDS) begin m_clr = 1'b0; m_idx = 0; end
      end else begin
        if (req_i && inr && we_i) begin
          w = gmem[addr_i[5:2]];
          for (int b = 0; b < 4; b++) if (be_i[b]) w[8*b +: 8] = wdata_i[8*b +: 8];
          gmem[addr_i[5:2]] = w;
        end
        if (clear_i) begin m_clr = 1'b1; m_idx = 0; end
      end
    end
  end

  task automatic acc(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0; clear_i = 1'b0;
  endtask

  // Counts falling edges with init_done_o low, starting just after reset release.
  task automatic count_clear(input string name);
    int n;
    int a0;
    n = 0;
    @(negedge clk);
    a0 = int'(ram_addr_o);
    while (!init_done_o && n < 100) begin n++; @(negedge clk); end
    chk({name, "_first_addr"}, 32'(a0), 32'h0);
    chk({name, "_cycles"}, 32'(n), 32'd16);
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0;
    wdata_i = '0; clear_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Test 1: clear after reset, requests held off.
    rst_n = 1'b1; req_i = 1'b1;
    count_clear("clear_on_reset");
    idle();
    // Test 2: write then read back, hold afterwards.
    acc(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    acc(1'b0, 32'h10, 4'hF, 32'h0);
    idle();
    @(negedge clk);
    chk("t2_rvalid", 32'(rvalid_o), 32'h1);
    chk("t2_rdata", rdata_o, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    chk("t2_hold", rdata_o, 32'hDEADBEEF);
    // Test 3: partial byte write on a cleared word.
    acc(1'b1, 32'h20, 4'b0101, 32'h11223344);
    acc(1'b0, 32'h20, 4'hF, 32'h0);
    idle();
    @(negedge clk);
    chk("t3_rdata", rdata_o, 32'h00220044);
    // Test 4: out-of-range read.
    acc(1'b0, 32'h1000, 4'hF, 32'h0);
    @(negedge clk);
    chk("t4_ram_en", 32'(ram_en_o), 32'h0);
    idle();
    @(negedge clk);
    chk("t4_err", {31'h0, err_o}, 32'h1);
    chk("t4_rdata", rdata_o, 32'h0);
    idle();
    @(negedge clk);
    chk("t4_hold", rdata_o, 32'h00220044);
    // Test 5: back-to-back reads.
    acc(1'b1, 32'h0, 4'hF, 32'hA0A0A0A0);
    acc(1'b1, 32'h4, 4'hF, 32'hA4A4A4A4);
    acc(1'b1, 32'h8, 4'hF, 32'hA8A8A8A8);
    acc(1'b0, 32'h0, 4'hF, 32'h0);
    acc(1'b0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    chk("t5_r0", rdata_o, 32'hA0A0A0A0);
    acc(1'b0, 32'h8, 4'hF, 32'h0);
    @(negedge clk);
    chk("t5_r1", rdata_o, 32'hA4A4A4A4);
    idle();
    @(negedge clk);
    chk("t5_r2", rdata_o, 32'hA8A8A8A8);
    chk("t5_rvalid", 32'(rvalid_o), 32'h1);
    // Test 6: clear with simultaneous write, reset mid-clear.
    acc(1'b1, 32'h8, 4'hF, 32'h55AA55AA);
    clear_i = 1'b1;
    idle();
    @(negedge clk);
    chk("t6_wr_rsp", {30'h0, rvalid_o, init_done_o}, 32'h2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_cnt5_addr", 32'(ram_addr_o), 32'h14);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_clear("clear_after_abort");
    acc(1'b0, 32'h8, 4'hF, 32'h0);
    idle();
    @(negedge clk);
    chk("t6_read_zero", rdata_o, 32'h0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sp_ram_port_ctrl.md
Name: sp_ram_port_ctrl

Overview:
Request/grant slave-port controller directly upstream of the single-port SRAM wrapper (sp_ram). It converts a req/gnt/rvalid memory bus into the SRAM's en/we/byte-enable strobes and aligns read data to a fixed 1-cycle response. It rejects out-of-range accesses with an error response. It contains a clear engine that zero-fills the whole array after reset or on demand, and holds off the bus while clearing.

Parameters:
ADDR_WIDTH, 14, byte-address width of the SRAM port (word address = ADDR_WIDTH-2 bits)
NUM_WORDS, 16384, memory size in bytes; power of two, <= 2**ADDR_WIDTH
CLEAR_ON_RESET, 1, 1: run zero-fill after reset release; 0: start in RUN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_i  in  1  bus request
gnt_o  out  1  request accepted this cycle
addr_i  in  32  byte address; bits [1:0] ignored
we_i  in  1  1 = write, 0 = read
be_i  in  4  byte enables, be_i[n] covers wdata_i[8n+7:8n]
wdata_i  in  32  write data
rvalid_o  out  1  response valid, exactly 1 cycle after grant
rdata_o  out  32  read data, valid with rvalid_o
err_o  out  1  error flag for the response, valid with rvalid_o
clear_i  in  1  pulse: start zero-fill (RUN state only)
init_done_o  out  1  1 when in RUN
ram_en_o  out  1  to sp_ram en_i (active high)
ram_we_o  out  1  to sp_ram we_i (active high)
ram_addr_o  out  ADDR_WIDTH  to sp_ram addr_i (byte address, [1:0] = 0)
ram_be_o  out  4  to sp_ram be_i
ram_wdata_o  out  32  to sp_ram wdata_i
ram_rdata_i  in  32  from sp_ram rdata_o (valid 1 cycle after read enable)

Behaviour:
- Clock: clk. Reset: asynchronous, active-low rst_n. All state asynchronously reset.
- Reset values:
  - rvalid_o=0, err_o=0, rdata_o=0, clear counter=0.
  - State=CLEAR if CLEAR_ON_RESET, else RUN. init_done_o therefore resets to !CLEAR_ON_RESET.
  - ram_en_o/ram_we_o follow the state (see CLEAR and RUN).
- FSM, two states:
  - CLEAR:
    - gnt_o=0. ram_en_o=1, ram_we_o=1, ram_be_o=4'hF, ram_wdata_o=0.
    - ram_addr_o = {cnt,2'b00}. cnt increments by 1 each cycle, 0 .. NUM_WORDS/4-1.
    - The cycle cnt==NUM_WORDS/4-1 is written; next state RUN, cnt<=0. Clear takes exactly NUM_WORDS/4 cycles.
    - req_i and clear_i are ignored in CLEAR.
  - RUN:
    - gnt_o = req_i (combinational, zero wait states).
    - clear_i=1 -> next state CLEAR. A request in the same cycle is still granted and its response is delivered normally in the first CLEAR cycle.
- Granted access in RUN:
  - In range (addr_i < NUM_WORDS):
    - ram_en_o=1, ram_we_o=we_i, ram_addr_o={addr_i[ADDR_WIDTH-1:2],2'b00}, ram_be_o=be_i, ram_wdata_o=wdata_i.
    - be_i=0 on a write still produces a response; no byte changes.
  - Out of range: ram_en_o=0; response with err_o=1, rdata_o=0.
  - No grant: ram_en_o=0, ram_we_o=0.
- Response:
  - rvalid_o=1 exactly the cycle after every grant; back-to-back grants give back-to-back rvalid. No response backpressure.
  - Read, in range: rdata_o = ram_rdata_i combinationally in the response cycle. The same value is captured into a hold register.
  - Outside read-response cycles, rdata_o = hold register (last read data). Writes and errors do not update the hold register.
  - Write response: err_o=0 for in-range writes; rdata_o shows the hold value.
  - err_o is driven only with rvalid_o, else 0.
- Reset mid-CLEAR aborts the clear. After release, clearing restarts at word 0 (if CLEAR_ON_RESET), else the block enters RUN with a partially cleared array.
- Reset in the cycle after a grant: the response is dropped (rvalid_o=0).

Test Plan:
1. NUM_WORDS=64, CLEAR_ON_RESET=1:
   - Release reset -> init_done_o=0 for exactly 16 cycles with ram_addr_o stepping 0x00..0x3C, we=1, be=F, wdata=0.
   - gnt_o=0 throughout despite req_i=1; then init_done_o=1.
2. Write 0xDEADBEEF @0x10 be=F, then read @0x10:
   - rvalid_o one cycle after each grant.
   - Read rdata_o=0xDEADBEEF, err_o=0.
   - rdata_o holds 0xDEADBEEF while idle afterwards.
3. Write 0x11223344 @0x20 be=4'b0101 onto cleared word, read back -> rdata_o=0x00220044.
4. Read @0x1000 with NUM_WORDS=64:
   - ram_en_o=0.
   - Next cycle rvalid_o=1, err_o=1, rdata_o=0.
   - Hold register unchanged (a following idle cycle still shows the last good read).
5. Back-to-back reads @0x0,0x4,0x8 on consecutive cycles -> rvalid_o high 3 consecutive cycles with data in order.
6. clear_i with a simultaneous write @0x8, then rst_n low at cnt=5 and released:
   - The write gets its response in the first CLEAR cycle.
   - After release the clear restarts at address 0x00 and completes 16 cycles.
   - Read @0x8 afterwards returns 0.
